// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch and decode: buffers {pc, inst} pairs in order,
// valid/ready on both sides, single-cycle flush for redirects.
module fetch_inst_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W-1:0] CNT_MAX = DEPTH;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    entry_t head;

    // Extra wrap bit distinguishes full (wrap differs) from empty (all equal).
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = rst && !flush && !full;
    assign out_valid = rst && !flush && !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_pc   = out_valid ? head.pc   : '0;
    assign out_inst = out_valid ? head.inst : '0;
    assign count    = rst ? count_q : '0;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; out_valid masks stale entries,
    // and leaving the array reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, inst: in_inst};
    end

    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
    a_count_ptrs:    assert property (@(posedge clk) disable iff (!rst) count_q == (wr_ptr - rd_ptr));
    a_count_bound:   assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_MAX);

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: per-cycle vector table plus a
// hand-written wrap/concurrent push-pop sequence.
module tb_fetch_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_inst_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iinst;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_cnt;
        logic        chk_cnt;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string tag, input logic r, input logic f, input logic iv,
                                input logic [31:0] ipc, input logic [31:0] iinst, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [31:0] e_pc,
                                input logic [31:0] e_inst, input logic [2:0] e_cnt, input logic chk_cnt);
        vec_t v;
        v.tag = tag; v.rst = r; v.flush = f; v.iv = iv; v.ipc = ipc; v.iinst = iinst;
        v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_cnt = e_cnt; v.chk_cnt = chk_cnt;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, sample outputs mid-cycle, then let the edge happen.
    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] ipc,
                         input logic [31:0] iinst, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_pc = ipc; in_inst = iinst; out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

        // tag, rst, flush, iv, in_pc, in_inst, ordy | in_ready, out_valid, out_pc, out_inst, count, chk_cnt
        add("rst_hold0", 0, 0, 1, 32'h8000_0000, 32'h0, 0,  0, 0, 32'h0, 32'h0, 0, 1);
        add("rst_hold1", 0, 0, 1, 32'h8000_0000, 32'h0, 0,  0, 0, 32'h0, 32'h0, 0, 1);
        add("rst_hold2", 0, 0, 1, 32'h8000_0000, 32'h0, 0,  0, 0, 32'h0, 32'h0, 0, 1);
        add("rst_rel",   1, 0, 0, 32'h0, 32'h0, 0,          1, 0, 32'h0, 32'h0, 0, 1);

        add("sp_push",   1, 0, 1, 32'h8000_0000, 32'h0000_0413, 0,  1, 0, 32'h0, 32'h0, 0, 1);
        add("sp_pop",    1, 0, 0, 32'h0, 32'h0, 1,                 1, 1, 32'h8000_0000, 32'h0000_0413, 1, 1);
        add("sp_empty",  1, 0, 0, 32'h0, 32'h0, 0,                 1, 0, 32'h0, 32'h0, 0, 1);

        add("fill0",     1, 0, 1, 32'h8000_0000, 32'h11, 0,  1, 0, 32'h0, 32'h0, 0, 1);
        add("fill1",     1, 0, 1, 32'h8000_0004, 32'h22, 0,  1, 1, 32'h8000_0000, 32'h11, 1, 1);
        add("fill2",     1, 0, 1, 32'h8000_0008, 32'h33, 0,  1, 1, 32'h8000_0000, 32'h11, 2, 1);
        add("fill3",     1, 0, 1, 32'h8000_000C, 32'h44, 0,  1, 1, 32'h8000_0000, 32'h11, 3, 1);
        add("full_hold", 1, 0, 1, 32'h8000_0010, 32'h55, 0,  0, 1, 32'h8000_0000, 32'h11, 4, 1);
        add("full_pop",  1, 0, 1, 32'h8000_0010, 32'h55, 1,  0, 1, 32'h8000_0000, 32'h11, 4, 1);
        add("drain1",    1, 0, 0, 32'h0, 32'h0, 1,           1, 1, 32'h8000_0004, 32'h22, 3, 1);
        add("drain2",    1, 0, 0, 32'h0, 32'h0, 1,           1, 1, 32'h8000_0008, 32'h33, 2, 1);
        add("drain3",    1, 0, 0, 32'h0, 32'h0, 1,           1, 1, 32'h8000_000C, 32'h44, 1, 1);
        add("drained",   1, 0, 0, 32'h0, 32'h0, 0,           1, 0, 32'h0, 32'h0, 0, 1);

        add("fl_push0",  1, 0, 1, 32'h8000_0010, 32'h10, 0,  1, 0, 32'h0, 32'h0, 0, 1);
        add("fl_push1",  1, 0, 1, 32'h8000_0014, 32'h14, 0,  1, 1, 32'h8000_0010, 32'h10, 1, 1);
        add("fl_push2",  1, 0, 1, 32'h8000_0018, 32'h18, 0,  1, 1, 32'h8000_0010, 32'h10, 2, 1);
        add("flush",     1, 1, 1, 32'h8000_0100, 32'h100, 1, 0, 0, 32'h0, 32'h0, 0, 0);
        add("fl_after",  1, 0, 0, 32'h0, 32'h0, 0,           1, 0, 32'h0, 32'h0, 0, 1);
        add("fl_repush", 1, 0, 1, 32'h8000_0100, 32'h100, 0, 1, 0, 32'h0, 32'h0, 0, 1);
        add("fl_head",   1, 0, 0, 32'h0, 32'h0, 1,           1, 1, 32'h8000_0100, 32'h100, 1, 1);
        add("fl_idle",   1, 0, 0, 32'h0, 32'h0, 0,           1, 0, 32'h0, 32'h0, 0, 1);

        add("rm_push0",  1, 0, 1, 32'h8000_0200, 32'h200, 0, 1, 0, 32'h0, 32'h0, 0, 1);
        add("rm_push1",  1, 0, 1, 32'h8000_0204, 32'h204, 0, 1, 1, 32'h8000_0200, 32'h200, 1, 1);
        add("rm_push2",  1, 0, 1, 32'h8000_0208, 32'h208, 0, 1, 1, 32'h8000_0200, 32'h200, 2, 1);
        add("rm_rst",    0, 0, 1, 32'h8000_020C, 32'h20C, 1, 0, 0, 32'h0, 32'h0, 0, 1);
        add("rm_rel",    1, 0, 0, 32'h0, 32'h0, 1,           1, 0, 32'h0, 32'h0, 0, 1);
        add("rm_idle",   1, 0, 0, 32'h0, 32'h0, 0,           1, 0, 32'h0, 32'h0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ipc, vecs[i].iinst, vecs[i].ordy);
            check({vecs[i].tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, vecs[i].e_ir});
            check({vecs[i].tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            check({vecs[i].tag, ".out_pc"},    out_pc,   vecs[i].e_pc);
            check({vecs[i].tag, ".out_inst"},  out_inst, vecs[i].e_inst);
            if (vecs[i].chk_cnt)
                check({vecs[i].tag, ".count"}, {29'b0, count}, {29'b0, vecs[i].e_cnt});
            finish_cycle();
        end

        // Wrap/concurrent: prime two entries, then push and pop together for 10 cycles.
        for (int k = 0; k < 2; k++) begin
            logic [31:0] pc;
            pc = 32'h8000_0020 + 32'(4 * k);
            drive(1, 0, 1, pc, pc ^ 32'h0000_AA00, 0);
            check("wrap_prime.in_ready", {31'b0, in_ready}, 32'd1);
            check("wrap_prime.count",    {29'b0, count},    32'(k));
            finish_cycle();
        end
        for (int j = 0; j < 10; j++) begin
            logic [31:0] pc_in, pc_hd;
            pc_in = 32'h8000_0028 + 32'(4 * j);
            pc_hd = 32'h8000_0020 + 32'(4 * j);
            drive(1, 0, 1, pc_in, pc_in ^ 32'h0000_AA00, 1);
            check("wrap.in_ready",  {31'b0, in_ready},  32'd1);
            check("wrap.out_valid", {31'b0, out_valid}, 32'd1);
            check("wrap.out_pc",    out_pc,   pc_hd);
            check("wrap.out_inst",  out_inst, pc_hd ^ 32'h0000_AA00);
            check("wrap.count",     {29'b0, count}, 32'd2);
            finish_cycle();
        end
        for (int j = 0; j < 2; j++) begin
            logic [31:0] pc_hd;
            pc_hd = 32'h8000_0048 + 32'(4 * j);
            drive(1, 0, 0, 32'h0, 32'h0, 1);
            check("wrap_drain.out_valid", {31'b0, out_valid}, 32'd1);
            check("wrap_drain.out_pc",    out_pc, pc_hd);
            check("wrap_drain.count",     {29'b0, count}, 32'(2 - j));
            finish_cycle();
        end
        drive(1, 0, 0, 32'h0, 32'h0, 1);
        check("wrap_end.out_valid", {31'b0, out_valid}, 32'd0);
        check("wrap_end.count",     {29'b0, count},     32'd0);
        finish_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Decoupling instruction queue between the instruction fetch stage and the decode stage of the npc core.
- Buffers {pc, inst} pairs produced by fetch and presents them in order to decode, using valid/ready handshakes on both sides.
- Supports a one-cycle flush for branch/jump/exception redirect, so fetch and decode can run at independent rates once the core goes multi-cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of pc and inst fields.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  discard all entries this cycle (redirect).
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  pc of the fetched instruction.
- in_inst  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_inst  output  XLEN  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries; wr_ptr/rd_ptr carry one extra wrap bit.
  - full = pointers equal except the wrap bit.
  - empty = pointers fully equal.
- Reset (rst==0 at posedge): wr_ptr=0, rd_ptr=0, count=0. Entry contents need not be cleared.
  - Outputs during and after reset: out_valid=0, out_pc=0, out_inst=0, in_ready=0 while rst==0, count=0.
  - Reset overrides flush and any handshake in the same cycle.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid/in_pc/in_inst are ignored when in_ready==0; fetch holds them stable until accepted.
- in_ready = rst & !flush & !full.
  - No pass-through when full: a simultaneous pop does not enable a push in that cycle.
- out_valid = rst & !flush & !empty.
- out_pc/out_inst = head entry when out_valid, else 0.
  - Combinational read of mem[rd_ptr]; no output register.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1 cycle). No in->out combinational bypass when empty.
- Push and pop in the same cycle (not empty, not full): both pointers advance; count unchanged.
- Pointer wrap: the index wraps DEPTH-1 -> 0 and the wrap bit toggles. FIFO order is preserved across the wrap.
- Flush (flush==1, rst==1):
  - At the edge: wr_ptr=rd_ptr=0 and count=0.
  - No push or pop takes effect in the flush cycle; in_ready=0 and out_valid=0 combinationally during it.
  - The next cycle behaves as post-reset empty.
- count:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - 0 on flush/reset.
  - Never exceeds DEPTH, never underflows.
- Assertions for verification:
  - No push when full; no pop when empty.
  - count equals wr_ptr-rd_ptr (with wrap bit).

Test Plan:
- Reset hold: rst=0 for 3 cycles with in_valid=1, in_pc=0x80000000 -> out_valid=0, in_ready=0, count=0. After rst=1: in_ready=1 in the first cycle, out_valid=0.
- Single pass: push {0x80000000, 0x00000413} with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_inst=0x00000413, count=1. Raise out_ready for 1 cycle -> out_valid=0, count=0.
- Fill/full: push 4 entries pc=0x80000000..0x8000000C with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is not accepted. Then pop all -> pcs emerge in order 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
- Wrap and concurrent: with count=2, keep in_valid=1 and out_ready=1 for 10 cycles, pc incrementing by 4 -> count stays 2, output pc sequence is contiguous, pointers wrap twice, no loss or duplication.
- Flush mid-stream: count=3 (heads 0x80000010..), assert flush with in_valid=1, in_pc=0x80000100 and out_ready=1 -> in_ready=0, out_valid=0 that cycle. Next cycle count=0, out_valid=0; a following push of 0x80000100 appears as the next head.
- Reset mid-operation: count=3, drive rst=0 for 1 cycle with in_valid=1 and out_ready=1 -> count=0, out_valid=0. No stale entry appears after release.
